// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: request opcodes, ALU control words and FSM states.
// Data vectors are declared [0:W-1], so bit 0 is the MSB (sign) and bit W-1 is the LSB.
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpAnd   = 4'd2,
        OpOr    = 4'd3,
        OpXor   = 4'd4,
        OpMul   = 4'd5,
        OpShift = 4'd6,
        OpSeq   = 4'd7,
        OpSne   = 4'd8,
        OpSlt   = 4'd9,
        OpSgt   = 4'd10,
        OpSle   = 4'd11,
        OpSge   = 4'd12
    } op_e;

    // Leftmost bit is carry-in/subtract; the remaining three select the ALU result.
    localparam logic [0:3] CtrlAnd   = 4'b0000;
    localparam logic [0:3] CtrlOr    = 4'b0001;
    localparam logic [0:3] CtrlXor   = 4'b0010;
    localparam logic [0:3] CtrlMul   = 4'b0011;
    localparam logic [0:3] CtrlShift = 4'b0100;
    localparam logic [0:3] CtrlAdd   = 4'b0101;
    localparam logic [0:3] CtrlSub   = 4'b1101;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMwait,
        StResp
    } state_e;

    // Reduce a subtraction result to the flag of a set-compare op.
    function automatic logic set_flag(input logic [3:0] op, input logic lt, input logic zero);
        logic flag;
        flag = 1'b0;
        case (op)
            OpSeq:   flag = zero;
            OpSne:   flag = !zero;
            OpSlt:   flag = lt;
            OpSgt:   flag = !lt && !zero;
            OpSle:   flag = lt || zero;
            OpSge:   flag = !lt;
            default: flag = 1'b0;
        endcase
        return flag;
    endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Opcode decoder: maps a request opcode to its ALU control word and classification flags.
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [0:3] o_ctrl,
    output logic       o_is_mul,
    output logic       o_is_set,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl    = CtrlAnd;
        o_is_mul  = 1'b0;
        o_is_set  = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OpAdd:   o_ctrl = CtrlAdd;
            OpSub:   o_ctrl = CtrlSub;
            OpAnd:   o_ctrl = CtrlAnd;
            OpOr:    o_ctrl = CtrlOr;
            OpXor:   o_ctrl = CtrlXor;
            OpMul: begin
                o_ctrl   = CtrlMul;
                o_is_mul = 1'b1;
            end
            OpShift: o_ctrl = CtrlShift;
            OpSeq, OpSne, OpSlt, OpSgt, OpSle, OpSge: begin
                o_ctrl   = CtrlSub;
                o_is_set = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer around an external combinational ALU; multiplies get a
// configurable settle window, set-compare ops are reduced from the ALU's subtraction.
module alu_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [0:WIDTH-1] req_a,
    input  logic [0:WIDTH-1] req_b,
    output logic [0:WIDTH-1] alu_a,
    output logic [0:WIDTH-1] alu_b,
    output logic [0:3]       alu_ctrl,
    input  logic [0:WIDTH-1] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [0:WIDTH-1] rsp_data,
    output logic             rsp_err
);

    import alu_sequencer_pkg::*;

    localparam logic [3:0] CntLoad = 4'(MUL_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [0:WIDTH-1] r_alu_a;
    logic [0:WIDTH-1] r_alu_b;
    logic [0:3]       r_alu_ctrl;
    logic [3:0]       r_op;
    logic             r_is_set;
    logic [3:0]       r_cnt;
    logic [0:WIDTH-1] r_rsp_data;
    logic             r_rsp_err;

    logic [0:3]       w_dec_ctrl;
    logic             w_dec_is_mul;
    logic             w_dec_is_set;
    logic             w_dec_illegal;
    logic             w_zero;
    logic             w_lt;
    logic [0:WIDTH-1] w_result;

    alu_op_decode u_decode (
        .i_op      (req_op),
        .o_ctrl    (w_dec_ctrl),
        .o_is_mul  (w_dec_is_mul),
        .o_is_set  (w_dec_is_set),
        .o_illegal (w_dec_illegal)
    );

    // Signed less-than from a - b: on differing signs the sign of a decides, avoiding overflow.
    assign w_zero   = (alu_out == '0);
    assign w_lt     = (r_alu_a[0] != r_alu_b[0]) ? r_alu_a[0] : alu_out[0];
    assign w_result = r_is_set ? {{(WIDTH-1){1'b0}}, set_flag(r_op, w_lt, w_zero)} : alu_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_dec_illegal) begin
                        w_state_next = StResp;
                    end else if (w_dec_is_mul) begin
                        w_state_next = StMwait;
                    end else begin
                        w_state_next = StExec;
                    end
                end
            end
            StExec:  w_state_next = StResp;
            StMwait: begin
                if (r_cnt == '0) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= CtrlAnd;
            r_op       <= '0;
            r_is_set   <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_alu_a    <= req_a;
                        r_alu_b    <= req_b;
                        r_alu_ctrl <= w_dec_ctrl;
                        r_op       <= req_op;
                        r_is_set   <= w_dec_is_set;
                        r_rsp_data <= '0;
                        r_rsp_err  <= w_dec_illegal;
                        if (w_dec_is_mul) begin
                            r_cnt <= CntLoad;
                        end
                    end
                end
                StExec:  r_rsp_data <= w_result;
                StMwait: begin
                    if (r_cnt == '0) begin
                        r_rsp_data <= w_result;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ctrl = r_alu_ctrl;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, directed corner cases and
// randomized ops checked against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [0:WIDTH-1] req_a;
    logic [0:WIDTH-1] req_b;
    logic [0:WIDTH-1] alu_a;
    logic [0:WIDTH-1] alu_b;
    logic [0:3]       alu_ctrl;
    logic [0:WIDTH-1] alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [0:WIDTH-1] rsp_data;
    logic             rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // External combinational ALU, modelled numerically.
    logic [31:0] ext_a, ext_b, ext_o;
    logic [3:0]  ext_ctrl;
    assign ext_a    = alu_a;
    assign ext_b    = alu_b;
    assign ext_ctrl = alu_ctrl;
    assign alu_out  = ext_o;
    always_comb begin
        ext_o = 32'hDEAD_BEEF;
        case (ext_ctrl)
            4'b0000: ext_o = ext_a & ext_b;
            4'b0001: ext_o = ext_a | ext_b;
            4'b0010: ext_o = ext_a ^ ext_b;
            4'b0011: ext_o = ext_a * ext_b;
            4'b0100: ext_o = ext_a << ext_b[4:0];
            4'b0101: ext_o = ext_a + ext_b;
            4'b1101: ext_o = ext_a - ext_b;
            default: ext_o = 32'hDEAD_BEEF;
        endcase
    end

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic e);
        e = 1'b0;
        case (op)
            4'd0:  d = a + b;
            4'd1:  d = a - b;
            4'd2:  d = a & b;
            4'd3:  d = a | b;
            4'd4:  d = a ^ b;
            4'd5:  d = a * b;
            4'd6:  d = a << b[4:0];
            4'd7:  d = {31'b0, a == b};
            4'd8:  d = {31'b0, a != b};
            4'd9:  d = {31'b0, $signed(a) <  $signed(b)};
            4'd10: d = {31'b0, $signed(a) >  $signed(b)};
            4'd11: d = {31'b0, $signed(a) <= $signed(b)};
            4'd12: d = {31'b0, $signed(a) >= $signed(b)};
            default: begin
                d = '0;
                e = 1'b1;
            end
        endcase
    endfunction

    function automatic logic [3:0] exp_ctrl(input logic [3:0] op);
        case (op)
            4'd0:    return 4'b0101;
            4'd1:    return 4'b1101;
            4'd2:    return 4'b0000;
            4'd3:    return 4'b0001;
            4'd4:    return 4'b0010;
            4'd5:    return 4'b0011;
            4'd6:    return 4'b0100;
            4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: return 4'b1101;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        if (op > 4'd12) return 1;
        if (op == 4'd5) return MUL_CYCLES + 1;
        return 2;
    endfunction

    // Issue one request, measure edges from accept to rsp_valid, hold rsp_ready low for
    // 'hold' cycles, then complete the handshake. lat = -2: never ready, -1: no response.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output int lat, output logic [31:0] data,
                          output logic err, output bit stable, output bit ready_low,
                          output logic [31:0] oa, output logic [31:0] ob,
                          output logic [3:0] octrl);
        int guard;
        lat = -2; data = 'x; err = 1'bx; stable = 1'b0; ready_low = 1'b1;
        oa = 'x; ob = 'x; octrl = 'x;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) return;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 1;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 40) begin
            if (req_ready) ready_low = 1'b0;
            @(negedge clk);
            lat++;
            guard++;
        end
        if (!rsp_valid) begin
            lat = -1;
            return;
        end
        data = rsp_data; err = rsp_err; oa = alu_a; ob = alu_b; octrl = alu_ctrl;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== data || rsp_err !== err || req_ready) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        #12;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_flags: got ready/valid/err=%b required 100",
                     {req_ready, rsp_valid, rsp_err});
        end
        n_checks++;
        if ({rsp_data, alu_a, alu_b, alu_ctrl} !== '0) begin
            n_errors++;
            $display("FAIL reset_regs: got data=%h a=%h b=%h ctrl=%b required all zero",
                     rsp_data, alu_a, alu_b, alu_ctrl);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_directed();
        int lat; logic [31:0] d; logic e; bit st, rl; logic [31:0] oa, ob; logic [3:0] oc;

        run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 0, lat, d, e, st, rl, oa, ob, oc);
        n_checks++;
        if (d !== 32'h8000_0000 || e !== 1'b0) begin
            n_errors++;
            $display("FAIL add_wrap: got %h err=%b required 80000000 err=0", d, e);
        end
        n_checks++;
        if (lat !== 2) begin
            n_errors++;
            $display("FAIL add_latency: got %0d required 2", lat);
        end

        run_op(4'd9, 32'h8000_0000, 32'h1, 0, lat, d, e, st, rl, oa, ob, oc);
        n_checks++;
        if (d !== 32'h1) begin
            n_errors++;
            $display("FAIL slt_neg: got %h required 00000001", d);
        end
        run_op(4'd10, 32'h8000_0000, 32'h1, 0, lat, d, e, st, rl, oa, ob, oc);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++;
            $display("FAIL sgt_neg: got %h required 00000000", d);
        end
        run_op(4'd7, 32'd5, 32'd5, 0, lat, d, e, st, rl, oa, ob, oc);
        n_checks++;
        if (d !== 32'h1) begin
            n_errors++;
            $display("FAIL seq_eq: got %h required 00000001", d);
        end

        run_op(4'd5, 32'd3, 32'd7, 0, lat, d, e, st, rl, oa, ob, oc);
        n_checks++;
        if (d !== 32'd21) begin
            n_errors++;
            $display("FAIL mul_data: got %0d required 21", d);
        end
        n_checks++;
        if (lat !== MUL_CYCLES + 1 || rl !== 1'b1) begin
            n_errors++;
            $display("FAIL mul_latency: got lat=%0d ready_low=%b required %0d 1",
                     lat, rl, MUL_CYCLES + 1);
        end

        run_op(4'd14, 32'hFFFF_FFFF, 32'h1234, 0, lat, d, e, st, rl, oa, ob, oc);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1 || oc !== 4'b0000) begin
            n_errors++;
            $display("FAIL illegal_rsp: got data=%h err=%b ctrl=%b required 0 1 0000", d, e, oc);
        end
        n_checks++;
        if (lat !== 1) begin
            n_errors++;
            $display("FAIL illegal_latency: got %0d required 1", lat);
        end
    endtask

    task automatic test_backpressure();
        int guard, lat;
        bit ok;
        logic [31:0] first;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd10; req_b = 32'd20;
        @(posedge clk);
        #1;
        // A second request stays presented and must wait for the handshake.
        req_op = 4'd1; req_a = 32'd100; req_b = 32'd1;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        first = rsp_data;
        n_checks++;
        if (rsp_valid !== 1'b1 || first !== 32'd30) begin
            n_errors++;
            $display("FAIL bp_first: got valid=%b data=%0d required 1 30", rsp_valid, first);
        end
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd30 || req_ready !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL bp_hold: got valid=%b data=%0d ready=%b required 1 30 0",
                     rsp_valid, rsp_data, req_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release: got ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            lat++;
            guard++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd99 || lat !== 2) begin
            n_errors++;
            $display("FAIL bp_second: got valid=%b data=%0d lat=%0d required 1 99 2",
                     rsp_valid, rsp_data, lat);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        int lat; logic [31:0] d; logic e; bit st, rl; logic [31:0] oa, ob; logic [3:0] oc;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd5; req_a = 32'd6; req_b = 32'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 ||
            {rsp_data, alu_a, alu_b, alu_ctrl} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: got ready=%b valid=%b err=%b data=%h a=%h b=%h ctrl=%b required 1 0 0 0 0 0 0000",
                     req_ready, rsp_valid, rsp_err, rsp_data, alu_a, alu_b, alu_ctrl);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL reset_abandon: got %0d cycles with response or busy required 0", seen);
        end
        run_op(4'd0, 32'd1, 32'd2, 0, lat, d, e, st, rl, oa, ob, oc);
        n_checks++;
        if (d !== 32'd3 || lat !== 2) begin
            n_errors++;
            $display("FAIL reset_recover: got data=%0d lat=%0d required 3 2", d, lat);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] d; logic e; bit st, rl; logic [31:0] oa, ob; logic [3:0] oc;
        logic [3:0] op; logic [31:0] a, b, md; logic me; int hold;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            b  = $urandom;
            case ($urandom_range(0, 4))
                0:       a = b;
                1:       a = 32'h8000_0000;
                2:       a = 32'h7FFF_FFFF;
                3:       a = 32'h0;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) b = 32'h8000_0000;
            hold = $urandom_range(0, 3);
            model(op, a, b, md, me);
            run_op(op, a, b, hold, lat, d, e, st, rl, oa, ob, oc);
            n_checks++;
            if (d !== md || e !== me) begin
                n_errors++;
                $display("FAIL rand_data: op=%0d a=%h b=%h got %h err=%b required %h err=%b",
                         op, a, b, d, e, md, me);
            end
            n_checks++;
            if (lat !== exp_lat(op)) begin
                n_errors++;
                $display("FAIL rand_latency: op=%0d got %0d required %0d", op, lat, exp_lat(op));
            end
            n_checks++;
            if (oc !== exp_ctrl(op)) begin
                n_errors++;
                $display("FAIL rand_ctrl: op=%0d got %b required %b", op, oc, exp_ctrl(op));
            end
            if (op <= 4'd12) begin
                n_checks++;
                if (oa !== a || ob !== b) begin
                    n_errors++;
                    $display("FAIL rand_operands: op=%0d got %h %h required %h %h",
                             op, oa, ob, a, b);
                end
            end
            n_checks++;
            if (st !== 1'b1) begin
                n_errors++;
                $display("FAIL rand_stable: op=%0d hold=%0d got unstable required stable", op, hold);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; bit 0 is the MSB on all data ports.
REQ-002 Parameter MUL_CYCLES, default 4, number of cycles the multiply path is allowed to settle (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SHIFT, 7 SEQ, 8 SNE, 9 SLT, 10 SGT, 11 SLE, 12 SGE; 13-15 illegal.
REQ-008 req_a, req_b  input  WIDTH each  operands.
REQ-009 alu_a, alu_b  output  WIDTH each  operands driven to the external combinational ALU.
REQ-010 alu_ctrl  output  4  ALU control: bit 0 = carry-in/subtract, bits 1:3 = result select.
REQ-011 alu_out  input  WIDTH  external ALU result.
REQ-012 rsp_valid  output  1  response present; rsp_ready  input  1  consumer accepts.
REQ-013 rsp_data  output  WIDTH  result; rsp_err  output  1  illegal opcode flag.

Function
REQ-014 alu_ctrl encoding SHALL be: AND 0000, OR 0001, XOR 0010, MUL 0011, SHIFT 0100, ADD 0101, SUB 1101; all set ops SHALL issue SUB (1101).
REQ-015 The FSM SHALL have states IDLE, EXEC, MWAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on req_valid&req_ready, register req_a/req_b onto alu_a/alu_b, register the decoded alu_ctrl and op, then go to EXEC (MWAIT for MUL, counter loaded with MUL_CYCLES-1).
REQ-017 EXEC SHALL last exactly one cycle; at its closing edge alu_out is captured into the result and the FSM goes to RESP.
REQ-018 MWAIT SHALL decrement the counter each cycle and capture alu_out at the edge where the counter is 0, then go to RESP; MUL latency SHALL be MUL_CYCLES+1 cycles accept-to-rsp_valid.
REQ-019 Non-MUL latency SHALL be 2 cycles from the accepting edge to rsp_valid=1.
REQ-020 Set ops SHALL produce 1 or 0 in WIDTH bits (LSB = bit WIDTH-1): SEQ out==0; SNE out!=0; SLT lt; SGT !lt & out!=0; SLE lt | out==0; SGE !lt; lt = (a[0]!=b[0]) ? a[0] : out[0] (signed, overflow-safe).
REQ-021 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-022 Illegal op SHALL skip EXEC, go directly to RESP with rsp_data=0, rsp_err=1; alu_ctrl = 0000.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&rsp_ready; then IDLE on that edge.
REQ-024 alu_a, alu_b, alu_ctrl SHALL hold their values from accept until the next accept.
REQ-025 req_* inputs SHALL be ignored outside IDLE; no request is lost because req_ready=0 there.

Reset
REQ-026 reset SHALL asynchronously force IDLE; req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, alu_a=0, alu_b=0, alu_ctrl=0000, counter=0.
REQ-027 Reset asserted mid-operation (EXEC, MWAIT, RESP) SHALL abandon the operation; no response is produced after release.

Structure
REQ-028 Op codes, ALU control codes and FSM state encodings SHALL live in a shared package with the ALU.
REQ-029 A sub-module alu_op_decode (op -> alu_ctrl, is_mul, is_set, illegal) SHALL be the only sub-module; the ALU itself is external.

Verification
REQ-030 ADD 0x7FFFFFFF + 1 -> rsp_data 0x80000000, rsp_valid 2 cycles after accept, rsp_err 0.
REQ-031 SLT a=0x80000000, b=0x00000001 -> 1; SGT same operands -> 0; SEQ 5,5 -> 1.
REQ-032 MUL 3*7 with MUL_CYCLES=4 -> 21, rsp_valid exactly 5 cycles after accept; req_ready 0 throughout.
REQ-033 rsp_ready held 0 for 10 cycles in RESP -> rsp_data stable, second req_valid not accepted until after handshake.
REQ-034 req_op=14 -> rsp_err 1, rsp_data 0, rsp_valid 1 cycle after accept.
REQ-035 reset pulse during MWAIT -> all outputs at reset values immediately, no rsp_valid after release.
